// File: rtl/mult_div_pkg.sv
// Shared types and widths for the multi-cycle MIPS multiply/divide engine.
package mult_div_pkg;

  localparam int unsigned MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MTHI = 2'b00,
    MD_MTLO = 2'b01,
    MD_MULT = 2'b10,
    MD_DIV  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_FIX  = 2'b11
  } md_state_t;

endpackage

// File: rtl/mult_div_seq_if.sv
// Issue/read bus between the pipeline (master) and the mult/div engine (slave).
interface mult_div_seq_if
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
);

  logic             start;
  logic             sin;
  md_op_t           op;
  logic [WIDTH-1:0] in_1;
  logic [WIDTH-1:0] in_2;
  logic             rd_en;
  logic             rd_sel;
  logic [WIDTH-1:0] rd_data;
  logic             stall;
  logic             busy;

  modport master (
    output start, sin, op, in_1, in_2, rd_en, rd_sel,
    input  rd_data, stall, busy
  );

  modport slave (
    input  start, sin, op, in_1, in_2, rd_en, rd_sel,
    output rd_data, stall, busy
  );

endinterface

// File: rtl/mult_div_seq_div_step.sv
// One restoring-division step: shift {rem,quo} left, subtract divisor if it fits.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // Low bits of the difference are exact whenever the subtraction is taken.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - divisor;
    if (shifted >= {1'b0, divisor}) begin
      rem_next = diff;
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_seq.sv
// Multi-cycle MIPS multiply/divide engine owning HI/LO, with the MFHI/MFLO read port.
// Define MULT_DIV_FAST_MULT_EN for a single-cycle multiply (IDLE -> FIX -> IDLE).
module mult_div_seq
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input logic           clk,
  input logic           reset,
  mult_div_seq_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned PW    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  md_state_t        state;
  logic             active;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CNT_W-1:0] count;

  logic [PW:0]      acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dividend_raw;
  logic             prod_neg;
  logic             quo_neg;
  logic             rem_neg;
  logic             div_zero;
  logic             is_div;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   mul_sum;
  logic [PW:0]      mul_next;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [PW-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

`ifdef MULT_DIV_FAST_MULT_EN
  logic [PW-1:0]    fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
`endif

  // Operand magnitudes; unsigned ops pass operands through untouched.
  always_comb begin
    a_neg = bus.sin & bus.in_1[WIDTH-1];
    b_neg = bus.sin & bus.in_2[WIDTH-1];
    a_abs = a_neg ? (~bus.in_1 + WIDTH'(1)) : bus.in_1;
    b_abs = b_neg ? (~bus.in_2 + WIDTH'(1)) : bus.in_2;
  end

  // Shift-add step: multiplier sits in the low half and is consumed LSB first.
  always_comb begin
    mul_sum  = acc[PW:WIDTH] + (acc[0] ? {1'b0, mcand} : {(WIDTH + 1){1'b0}});
    mul_next = {1'b0, mul_sum, acc[WIDTH-1:1]};
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Sign correction applied in FIX; INT_MIN / -1 falls out as INT_MIN with rem 0.
  always_comb begin
    prod_fix = prod_neg ? (~acc[PW-1:0] + PW'(1)) : acc[PW-1:0];
    quo_fix  = quo_neg ? (~quo + WIDTH'(1)) : quo;
    rem_fix  = rem_neg ? (~rem + WIDTH'(1)) : rem;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      active       <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      count        <= '0;
      acc          <= '0;
      mcand        <= '0;
      divisor      <= '0;
      rem          <= '0;
      quo          <= '0;
      dividend_raw <= '0;
      prod_neg     <= 1'b0;
      quo_neg      <= 1'b0;
      rem_neg      <= 1'b0;
      div_zero     <= 1'b0;
      is_div       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              MD_MTHI: hi <= bus.in_1;
              MD_MTLO: lo <= bus.in_1;
              MD_MULT: begin
                mcand    <= a_abs;
                prod_neg <= a_neg ^ b_neg;
                is_div   <= 1'b0;
                count    <= '0;
                active   <= 1'b1;
`ifdef MULT_DIV_FAST_MULT_EN
                acc      <= {1'b0, fast_prod};
                state    <= S_FIX;
`else
                acc      <= {{(WIDTH + 1){1'b0}}, b_abs};
                state    <= S_MUL;
`endif
              end
              MD_DIV: begin
                rem          <= '0;
                quo          <= a_abs;
                divisor      <= b_abs;
                quo_neg      <= a_neg ^ b_neg;
                rem_neg      <= a_neg;
                div_zero     <= (bus.in_2 == '0);
                dividend_raw <= bus.in_1;
                is_div       <= 1'b1;
                count        <= '0;
                active       <= 1'b1;
                state        <= S_DIV;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          acc   <= mul_next;
          count <= count + CNT_W'(1);
          if (count == LAST) state <= S_FIX;
        end
        S_DIV: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count + CNT_W'(1);
          if (count == LAST) state <= S_FIX;
        end
        S_FIX: begin
          if (!is_div) begin
            {hi, lo} <= prod_fix;
          end else if (div_zero) begin
            hi <= dividend_raw;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          active <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read port interlocks against any op in flight.
  assign bus.busy    = active;
  assign bus.stall   = bus.rd_en & active;
  assign bus.rd_data = (bus.rd_en && !active) ? (bus.rd_sel ? hi : lo) : '0;

endmodule
